// File: rtl/led_div_pkg.sv
// Shared types and constants for the LED divider bank.
package led_div_pkg;

    // Phase-length and counter width used when no override is given
    localparam int LED_CW = 10;

    // Default phase lengths, matching the original fixed 8/8 LED divider
    localparam int DEF_HIGH_C = 8;
    localparam int DEF_LOW_C  = 8;

    // Phase-length type at the default width
    typedef logic [LED_CW-1:0] phase_len_t;

    // Channel phase states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    // State entered after a reload, chosen from the freshly loaded lengths.
    // With both lengths zero the channel parks in LOW (hold mode).
    function automatic state_e reload_state(input logic low_nz, input logic high_nz);
        state_e st;
        if (low_nz) begin
            st = ST_LOW;
        end else if (high_nz) begin
            st = ST_HIGH;
        end else begin
            st = ST_LOW;
        end
        return st;
    endfunction

endpackage

// File: rtl/led_div_chan.sv
// One divider channel: configuration and active length registers,
// IDLE/LOW/HIGH phase machine, phase counter and registered led/tick.
module led_div_chan
    import led_div_pkg::*;
#(
    parameter int CW       = LED_CW,
    parameter int DEF_HIGH = DEF_HIGH_C,
    parameter int DEF_LOW  = DEF_LOW_C
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_high,
    input  logic [CW-1:0] cfg_low,
    input  logic          enable,
    output logic          led,
    output logic          tick
);

    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cfg_high_r;
    logic [CW-1:0] cfg_low_r;
    logic [CW-1:0] act_high_r;
    logic [CW-1:0] act_low_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    state_e        state_r;
    state_e        state_nxt_s;
    logic          led_r;
    logic          tick_r;
    logic          reload_s;
    logic          tick_nxt_s;
    logic          act_zero_s;
    logic          new_low_nz_s;
    logic          new_high_nz_s;

    assign led  = led_r;
    assign tick = tick_r;

    // Next-state, counter, reload and tick decisions for the phase machine
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        reload_s      = 1'b0;
        tick_nxt_s    = 1'b0;
        act_zero_s    = (act_low_r == ZERO) && (act_high_r == ZERO);
        new_low_nz_s  = (cfg_low_r != ZERO);
        new_high_nz_s = (cfg_high_r != ZERO);
        if (!enable) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    reload_s    = 1'b1;
                    cnt_nxt_s   = ZERO;
                    state_nxt_s = reload_state(new_low_nz_s, new_high_nz_s);
                end
                ST_LOW: begin
                    if (act_zero_s) begin
                        // hold mode: keep sampling the configuration, no tick
                        reload_s    = 1'b1;
                        cnt_nxt_s   = ZERO;
                        state_nxt_s = reload_state(new_low_nz_s, new_high_nz_s);
                    end else if (cnt_r == (act_low_r - ONE)) begin
                        cnt_nxt_s = ZERO;
                        if (act_high_r != ZERO) begin
                            state_nxt_s = ST_HIGH;
                        end else begin
                            // low-only waveform: each LOW phase is a full period
                            reload_s    = 1'b1;
                            tick_nxt_s  = 1'b1;
                            state_nxt_s = reload_state(new_low_nz_s, new_high_nz_s);
                        end
                    end else begin
                        cnt_nxt_s = cnt_r + ONE;
                    end
                end
                ST_HIGH: begin
                    if (cnt_r == (act_high_r - ONE)) begin
                        cnt_nxt_s   = ZERO;
                        reload_s    = 1'b1;
                        tick_nxt_s  = 1'b1;
                        state_nxt_s = reload_state(new_low_nz_s, new_high_nz_s);
                    end else begin
                        cnt_nxt_s = cnt_r + ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = ZERO;
                end
            endcase
        end
    end

    // Configuration registers, written by the channel's decoded strobe
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cfg_high_r <= CW'(DEF_HIGH);
            cfg_low_r  <= CW'(DEF_LOW);
        end else if (cfg_we) begin
            cfg_high_r <= cfg_high;
            cfg_low_r  <= cfg_low;
        end else begin
            cfg_high_r <= cfg_high_r;
            cfg_low_r  <= cfg_low_r;
        end
    end

    // Active lengths copy the pre-write configuration on reload edges only
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            act_high_r <= CW'(DEF_HIGH);
            act_low_r  <= CW'(DEF_LOW);
        end else if (reload_s) begin
            act_high_r <= cfg_high_r;
            act_low_r  <= cfg_low_r;
        end else begin
            act_high_r <= act_high_r;
            act_low_r  <= act_low_r;
        end
    end

    // Phase state, counter and registered outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= ZERO;
            led_r   <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            led_r   <= (state_nxt_s == ST_HIGH);
            tick_r  <= tick_nxt_s;
        end
    end

endmodule

// File: rtl/led_divider_bank.sv
// Bank of CH independently programmable LED divider / PWM channels.
// cfg_ch is decoded into one write strobe per channel; out-of-range
// channel numbers match no channel and are dropped.
module led_divider_bank
    import led_div_pkg::*;
#(
    parameter int  CH       = 4,
    parameter int  CW       = LED_CW,
    parameter int  DEF_HIGH = DEF_HIGH_C,
    parameter int  DEF_LOW  = DEF_LOW_C,
    localparam int CHW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_high,
    input  logic [CW-1:0]  cfg_low,
    input  logic [CH-1:0]  enable,
    output logic [CH-1:0]  led,
    output logic [CH-1:0]  tick
);

    logic [CH-1:0] we_vec_s;

    // Channel-select decode of the shared configuration write strobe
    always_comb begin
        we_vec_s = {CH{1'b0}};
        for (int i = 0; i < CH; i++) begin
            if (cfg_we && (cfg_ch == CHW'(i))) begin
                we_vec_s[i] = 1'b1;
            end else begin
                we_vec_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_chan
        led_div_chan #(
            .CW       (CW),
            .DEF_HIGH (DEF_HIGH),
            .DEF_LOW  (DEF_LOW)
        ) u_chan (
            .sys_clk  (sys_clk),
            .sys_rst  (sys_rst),
            .cfg_we   (we_vec_s[g]),
            .cfg_high (cfg_high),
            .cfg_low  (cfg_low),
            .enable   (enable[g]),
            .led      (led[g]),
            .tick     (tick[g])
        );
    end

endmodule

// File: tb/tb_led_divider_bank.sv
// Scoreboard bench for led_divider_bank: a 4-channel bank plus a 3-channel
// bank (where cfg_ch=3 is out of range). A per-channel period model pushes
// expected led/tick for every edge; values are popped and compared after it.
module tb_led_divider_bank;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [9:0] cfg_high;
    logic [9:0] cfg_low;
    logic [3:0] enable;
    logic [3:0] led;
    logic [3:0] tick;

    logic       cfg_we_odd;
    logic [1:0] cfg_ch_odd;
    logic [2:0] en_odd;
    logic [2:0] led_odd;
    logic [2:0] tick_odd;

    int n_total = 0;
    int n_bad   = 0;

    // model state, channels 0..3 main bank, 4..6 three-channel bank
    int m_run [7];
    int m_ph  [7];
    int m_rem [7];
    int m_alo [7];
    int m_ahi [7];
    int m_clo [7];
    int m_chi [7];

    logic [13:0] exp_q [$];

    always #5 sys_clk = ~sys_clk;

    led_divider_bank #(.CH(4), .CW(10), .DEF_HIGH(8), .DEF_LOW(8)) u_dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_high (cfg_high),
        .cfg_low  (cfg_low),
        .enable   (enable),
        .led      (led),
        .tick     (tick)
    );

    led_divider_bank #(.CH(3), .CW(10), .DEF_HIGH(8), .DEF_LOW(8)) u_odd (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .cfg_we   (cfg_we_odd),
        .cfg_ch   (cfg_ch_odd),
        .cfg_high (cfg_high),
        .cfg_low  (cfg_low),
        .enable   (en_odd),
        .led      (led_odd),
        .tick     (tick_odd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic start_period(input int k);
        if (m_alo[k] > 0) begin
            m_ph[k]  = 0;
            m_rem[k] = m_alo[k];
        end else if (m_ahi[k] > 0) begin
            m_ph[k]  = 1;
            m_rem[k] = m_ahi[k];
        end else begin
            m_ph[k]  = 0;
            m_rem[k] = 0;
        end
    endtask

    // advance the model by one edge using the inputs currently driven
    task automatic model_step(output logic [6:0] el, output logic [6:0] et);
        for (int k = 0; k < 7; k++) begin
            logic en;
            logic we;
            el[k] = 1'b0;
            et[k] = 1'b0;
            if (k < 4) begin
                en = enable[k];
                we = cfg_we && (int'(cfg_ch) == k);
            end else begin
                en = en_odd[k-4];
                we = cfg_we_odd && (int'(cfg_ch_odd) == k - 4);
            end
            if (sys_rst) begin
                m_run[k] = 0; m_ph[k] = 0; m_rem[k] = 0;
                m_alo[k] = 8; m_ahi[k] = 8; m_clo[k] = 8; m_chi[k] = 8;
            end else begin
                if (!en) begin
                    m_run[k] = 0;
                end else if (m_run[k] == 0 || (m_alo[k] == 0 && m_ahi[k] == 0)) begin
                    m_run[k] = 1;
                    m_alo[k] = m_clo[k];
                    m_ahi[k] = m_chi[k];
                    start_period(k);
                end else begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        if (m_ph[k] == 0 && m_ahi[k] > 0) begin
                            m_ph[k]  = 1;
                            m_rem[k] = m_ahi[k];
                        end else begin
                            m_alo[k] = m_clo[k];
                            m_ahi[k] = m_chi[k];
                            et[k]    = 1'b1;
                            start_period(k);
                        end
                    end
                end
                el[k] = (m_run[k] != 0) && (m_ph[k] == 1);
                if (we) begin
                    m_clo[k] = int'(cfg_low);
                    m_chi[k] = int'(cfg_high);
                end
            end
        end
    endtask

    // true when the coming edge is a period-ending reload for channel k
    function automatic logic ends_next(input int k);
        return (m_run[k] != 0) && !(m_alo[k] == 0 && m_ahi[k] == 0) &&
               (m_rem[k] == 1) && (m_ph[k] == 1 || m_ahi[k] == 0);
    endfunction

    task automatic step();
        logic [6:0]  el;
        logic [6:0]  et;
        logic [13:0] e;
        model_step(el, et);
        exp_q.push_back({et, el});
        @(posedge sys_clk);
        #1;
        e = exp_q.pop_front();
        chk("led", {25'd0, led_odd, led}, {25'd0, e[6:0]});
        chk("tick", {25'd0, tick_odd, tick}, {25'd0, e[13:7]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [1:0] ch, input logic [9:0] hi, input logic [9:0] lo);
        cfg_we = 1'b1; cfg_ch = ch; cfg_high = hi; cfg_low = lo;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic wr_odd(input logic [1:0] ch, input logic [9:0] hi, input logic [9:0] lo);
        cfg_we_odd = 1'b1; cfg_ch_odd = ch; cfg_high = hi; cfg_low = lo;
        step();
        cfg_we_odd = 1'b0;
    endtask

    initial begin
        int n;
        sys_rst = 1'b1; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_high = 10'd0; cfg_low = 10'd0;
        enable = 4'd0; cfg_we_odd = 1'b0; cfg_ch_odd = 2'd0; en_odd = 3'd0;
        @(negedge sys_clk);
        run(2);
        sys_rst = 1'b0;

        // defaults 8/8 on channel 0 and on the three-channel bank
        enable[0] = 1'b1;
        en_odd    = 3'b111;
        run(40);

        // mid-period write on channel 1
        enable[1] = 1'b1;
        run(5);
        wr(2'd1, 10'd3, 10'd5);
        run(30);

        // write landing exactly on a reload edge of channel 1
        n = 0;
        while (!ends_next(1) && n < 100) begin step(); n++; end
        chk("wait_reload_ch1", n < 100, 1);
        wr(2'd1, 10'd2, 10'd2);
        run(24);

        // zero-length phases on channel 2
        wr(2'd2, 10'd4, 10'd0);
        enable[2] = 1'b1;
        run(20);
        wr(2'd2, 10'd0, 10'd6);
        run(30);
        wr(2'd2, 10'd0, 10'd0);
        run(20);
        wr(2'd2, 10'd2, 10'd2);
        run(12);

        // disable channel 3 in the middle of HIGH, then re-enable
        wr(2'd3, 10'd6, 10'd3);
        enable[3] = 1'b1;
        n = 0;
        while (!(m_run[3] != 0 && m_ph[3] == 1 && m_rem[3] == 3) && n < 100) begin step(); n++; end
        chk("wait_high_ch3", n < 100, 1);
        enable[3] = 1'b0;
        run(5);
        enable[3] = 1'b1;
        run(20);

        // three-channel bank: a valid write and an out-of-range one
        wr_odd(2'd0, 10'd2, 10'd3);
        wr_odd(2'd3, 10'd1, 10'd1);
        run(30);

        // distinct settings everywhere, then reset mid-run
        wr(2'd0, 10'd2, 10'd1);
        wr(2'd1, 10'd1, 10'd2);
        wr(2'd2, 10'd5, 10'd3);
        wr(2'd3, 10'd3, 10'd4);
        run(15);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        run(40);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
